// File: rtl/acc_scale_multi.sv
// rtl/acc_scale_multi.sv - per-channel unsigned fixed-point gain with rounding, saturation stats
// and a double-buffered coefficient table; fixed 4-cycle pipeline carrying the header alongside.
module acc_scale_multi #(
  parameter int CH_NUM   = 32,
  parameter int DW       = 16,
  parameter int HEAD_WD  = 64,
  parameter int COE_WD   = 16,
  parameter int COE_FRAC = 8,
  parameter int FLAG_BIT = 63,
  parameter int AW       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_acc_en,
  input  logic                 cfg_coe_we,
  input  logic [AW-1:0]        cfg_coe_addr,
  input  logic [COE_WD-1:0]    cfg_coe_wdat,
  input  logic                 cfg_coe_commit,
  input  logic                 cfg_sat_clr,
  input  logic                 acc_ivld,
  input  logic [CH_NUM*DW-1:0] acc_idat,
  input  logic [HEAD_WD-1:0]   enc_idat,
  output logic                 acc_ovld,
  output logic [CH_NUM*DW-1:0] acc_odat,
  output logic [HEAD_WD-1:0]   enc_odat,
  output logic                 coe_pending,
  output logic                 sat_flag,
  output logic [31:0]          sat_cnt
);

  localparam int PW = DW + COE_WD;
  localparam logic [COE_WD-1:0] COE_UNITY = COE_WD'(1) << COE_FRAC;

  // coefficient banks
  logic [CH_NUM-1:0][COE_WD-1:0] r_shadow;
  logic [CH_NUM-1:0][COE_WD-1:0] r_active;
  logic                          r_coe_pending;
  logic                          w_pend_req;
  logic                          w_apply;
  logic                          w_addr_ok;

  // pipeline stages
  logic                          r_s1_vld;
  logic                          r_s1_en;
  logic [CH_NUM*DW-1:0]          r_s1_dat;
  logic [HEAD_WD-1:0]            r_s1_hdr;
  logic [CH_NUM-1:0][COE_WD-1:0] r_s1_coe;

  logic                          r_s2_vld;
  logic                          r_s2_en;
  logic [CH_NUM*DW-1:0]          r_s2_dat;
  logic [HEAD_WD-1:0]            r_s2_hdr;
  logic [CH_NUM-1:0][PW-1:0]     r_s2_prod;

  logic                          r_s3_vld;
  logic [CH_NUM-1:0][DW-1:0]     r_s3_dat;
  logic [HEAD_WD-1:0]            r_s3_hdr;
  logic [CH_NUM-1:0]             r_s3_sat;

  logic                          r_s4_vld;
  logic [CH_NUM*DW-1:0]          r_s4_dat;
  logic [HEAD_WD-1:0]            r_s4_hdr;
  logic                          r_s4_sat;

  logic                          r_sat_flag;
  logic [31:0]                   r_sat_cnt;

  logic [CH_NUM-1:0][PW-1:0]     w_prod;
  logic [CH_NUM-1:0][PW:0]       w_rnd;
  logic [CH_NUM-1:0][DW-1:0]     w_res;
  logic [CH_NUM-1:0]             w_ovf;
  logic [CH_NUM-1:0]             w_sat;

  if (CH_NUM == (1 << AW)) begin : g_addr_full
    assign w_addr_ok = 1'b1;
  end else begin : g_addr_part
    assign w_addr_ok = (32'(cfg_coe_addr) < 32'(CH_NUM));
  end

  // A commit is held until an idle input cycle so the S1 snapshot never sees a half-copied bank.
  assign w_pend_req = r_coe_pending | cfg_coe_commit;
  assign w_apply    = w_pend_req & ~acc_ivld;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow      <= {CH_NUM{COE_UNITY}};
      r_active      <= {CH_NUM{COE_UNITY}};
      r_coe_pending <= 1'b0;
    end else begin
      if (w_apply) begin
        r_active <= r_shadow;
      end
      if (cfg_coe_we && w_addr_ok) begin
        r_shadow[cfg_coe_addr] <= cfg_coe_wdat;
      end
      r_coe_pending <= w_pend_req & acc_ivld;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s1_en  <= 1'b0;
      r_s1_dat <= '0;
      r_s1_hdr <= '0;
      r_s1_coe <= {CH_NUM{COE_UNITY}};
    end else begin
      r_s1_vld <= acc_ivld;
      r_s1_en  <= cfg_acc_en & enc_idat[FLAG_BIT];
      r_s1_dat <= acc_idat;
      r_s1_hdr <= enc_idat;
      r_s1_coe <= r_active;
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    assign w_prod[g] = PW'(r_s1_dat[g*DW +: DW]) * PW'(r_s1_coe[g]);

    if (COE_FRAC > 0) begin : g_rnd
      localparam logic [PW:0] RND_HALF = (PW+1)'(1) << (COE_FRAC - 1);
      logic [PW:0] w_sum;
      assign w_sum    = {1'b0, r_s2_prod[g]} + RND_HALF;
      assign w_rnd[g] = w_sum >> COE_FRAC;
    end else begin : g_nornd
      assign w_rnd[g] = {1'b0, r_s2_prod[g]};
    end

    // bypassed beats never report saturation
    assign w_ovf[g] = |w_rnd[g][PW:DW];
    assign w_sat[g] = r_s2_en & w_ovf[g];
    assign w_res[g] = !r_s2_en ? r_s2_dat[g*DW +: DW] :
                      w_ovf[g] ? {DW{1'b1}} : w_rnd[g][DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_vld  <= 1'b0;
      r_s2_en   <= 1'b0;
      r_s2_dat  <= '0;
      r_s2_hdr  <= '0;
      r_s2_prod <= '0;
    end else begin
      r_s2_vld  <= r_s1_vld;
      r_s2_en   <= r_s1_en;
      r_s2_dat  <= r_s1_dat;
      r_s2_hdr  <= r_s1_hdr;
      r_s2_prod <= w_prod;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s3_vld <= 1'b0;
      r_s3_dat <= '0;
      r_s3_hdr <= '0;
      r_s3_sat <= '0;
    end else begin
      r_s3_vld <= r_s2_vld;
      r_s3_dat <= w_res;
      r_s3_hdr <= r_s2_hdr;
      r_s3_sat <= w_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s4_vld <= 1'b0;
      r_s4_dat <= '0;
      r_s4_hdr <= '0;
      r_s4_sat <= 1'b0;
    end else begin
      r_s4_vld <= r_s3_vld;
      r_s4_dat <= r_s3_dat;
      r_s4_hdr <= r_s3_hdr;
      r_s4_sat <= |r_s3_sat;
    end
  end

  // statistics follow the beat presented on the outputs; clear wins over a same-cycle count
  always_ff @(posedge clk) begin
    if (rst || cfg_sat_clr) begin
      r_sat_flag <= 1'b0;
      r_sat_cnt  <= '0;
    end else if (r_s4_vld && r_s4_sat) begin
      r_sat_flag <= 1'b1;
      if (r_sat_cnt != 32'hFFFF_FFFF) begin
        r_sat_cnt <= r_sat_cnt + 32'd1;
      end
    end
  end

  assign acc_ovld    = r_s4_vld;
  assign acc_odat    = r_s4_dat;
  assign enc_odat    = r_s4_hdr;
  assign coe_pending = r_coe_pending;
  assign sat_flag    = r_sat_flag;
  assign sat_cnt     = r_sat_cnt;

endmodule

// File: doc/acc_scale_multi.md
# acc_scale_multi

Parametrised successor to the fixed 32-channel accumulator gain stage in the FIR control path. Applies an independent unsigned fixed-point gain to each of CH_NUM packed ADC channels, gated by a header flag bit. Adds rounding, saturation with statistics, and a double-buffered per-channel coefficient table that can be reloaded without glitching a frame. Sits between the accumulator and the packetiser in a single clock domain, with a fixed pipeline latency and the header carried alongside the data.

## Interface
- CH_NUM, 32, number of packed channels (1..64)
- DW, 16, bits per channel sample (unsigned)
- HEAD_WD, 64, header width carried with data
- COE_WD, 16, coefficient width (unsigned)
- COE_FRAC, 8, fractional bits of coefficient (0..COE_WD-1)
- FLAG_BIT, 63, header bit enabling scaling for the beat
- AW, $clog2(CH_NUM) (min 1), coefficient address width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cfg_acc_en  in  1  global scale enable, already in clk domain
- cfg_coe_we  in  1  write strobe into shadow coefficient bank
- cfg_coe_addr  in  AW  channel index for write
- cfg_coe_wdat  in  COE_WD  coefficient value
- cfg_coe_commit  in  1  request shadow→active bank copy (pulse)
- cfg_sat_clr  in  1  clear sat_flag and sat_cnt (pulse)
- acc_ivld  in  1  input beat valid
- acc_idat  in  CH_NUM*DW  channel i at [DW*(i+1)-1 : DW*i]
- enc_idat  in  HEAD_WD  header for the beat
- acc_ovld  out  1  output beat valid
- acc_odat  out  CH_NUM*DW  scaled or passed-through data, same packing
- enc_odat  out  HEAD_WD  header, delayed to align with acc_odat
- coe_pending  out  1  commit requested, not yet applied
- sat_flag  out  1  sticky: any channel saturated since last clear
- sat_cnt  out  32  number of beats containing at least one saturated channel

## Operation
- Stage S1: register acc_idat, enc_idat, acc_ivld. Capture scale_en = cfg_acc_en & enc_idat[FLAG_BIT] and a snapshot of the active bank.
- Stage S2: per channel, prod = data × coe; width DW+COE_WD, unsigned.
- Stage S3: when COE_FRAC>0, rnd = (prod + 2^(COE_FRAC-1)) >> COE_FRAC, which is round-half-up. When COE_FRAC=0, rnd = prod.
  - If rnd > 2^DW-1, the output is all-ones and the channel is marked saturated.
  - If scale_en=0, the output is the S1 data unchanged and no saturation is marked.
- Stage S4: register outputs.
- Data beats are processed whether or not acc_ivld is high. Outputs always follow the pipeline; consumers qualify with acc_ovld.
- Coefficient banks:
  - Shadow write: on cfg_coe_we, shadow[cfg_coe_addr] <= cfg_coe_wdat. Writes with addr ≥ CH_NUM are ignored.
  - cfg_coe_commit sets coe_pending.
  - The active bank copies the whole shadow and coe_pending clears at the end of the first cycle with coe_pending=1 and acc_ivld=0. A commit arriving on a cycle with acc_ivld=0 is applied that same cycle.
  - Because the bank is snapshotted at S1, no beat ever mixes old and new coefficients.
  - A shadow write in the same cycle as the copy is lost to that copy and stays in the shadow.
- Statistics:
  - When an S4 beat has acc_ovld=1 and any channel is saturated, sat_flag <= 1 and sat_cnt increments, saturating at 0xFFFFFFFF.
  - cfg_sat_clr has priority over a simultaneous increment: the result is sat_flag=0, sat_cnt=0.

## Timing
- Latency is exactly 4 clk from input to output. acc_ovld(t+4) = acc_ivld(t), with enc_odat and acc_odat aligned to it. Throughput is 1 beat/clk, with no back-pressure.
- Reset values: acc_ovld=0, acc_odat=0, enc_odat=0, coe_pending=0, sat_flag=0, sat_cnt=0. All shadow and active coefficients reset to 2^COE_FRAC (unity gain).
- Reset mid-stream flushes all in-flight valids: acc_ovld stays 0 for 4 cycles after rst deasserts unless new beats arrive. Pending commits and shadow writes are discarded.
- cfg_acc_en and FLAG_BIT take effect per beat at S1, with no additional sync delay.
- The copy under continuous acc_ivld=1 waits indefinitely; coe_pending stays high.

## Test plan
- Reset, then a beat with all channels 0x1234, FLAG_BIT=1, cfg_acc_en=1 → 4 cycles later acc_odat is all 0x1234 (unity), enc_odat equals the input header, acc_ovld is a single pulse.
- Shadow ch0=0x0180 (1.5), ch1=0x0080 (0.5), commit while idle, then data ch0=0x0003, ch1=0x0003 → out ch0=0x0005 (4.5 rounds up), ch1=0x0002 (1.5 rounds up); other channels unchanged.
- ch2 coefficient 0x0200, data 0x9000, scaling enabled → ch2 output 0xFFFF, sat_flag=1, sat_cnt=1. Repeat with FLAG_BIT=0 → output 0x9000, sat_cnt still 1.
- Commit issued during 10 back-to-back beats → coe_pending stays 1. The first gap applies the new bank. Every beat before the gap uses the old gain and every beat after uses the new one, with no mixed beat.
- cfg_sat_clr in the same cycle as a saturating S4 beat → sat_cnt=0, sat_flag=0.
- Assert rst for 1 cycle with 3 beats in flight → no acc_ovld for those beats. Outputs are 0 and coefficients are back to 0x0100.
